sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 34 +++
 rtl/sram_pin_drv.sv | 71 +++++++
 rtl/sram_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared sizes, FSM state encoding and grant types for the SRAM arbiter.
// The round-robin tie-break helper is only referenced when SRAM_ARBITER_RR_EN is defined.
package sram_arb_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        RD_ADDR   = 3'd3,
        RD_CAPT   = 3'd4
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    // A tie goes to whichever requester did not win last time.
    function automatic grant_t pick_grant(input logic wr_req, input logic rd_req, input grant_t last_gnt);
        grant_t gnt;
        if (wr_req && rd_req) begin
            gnt = (last_gnt == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (wr_req) begin
            gnt = GNT_WR;
        end else begin
            gnt = GNT_RD;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sram_pin_drv.sv
// SRAM pin-level drive: registered strobes decoded from the arbiter's next state
// and the tri-state data bus. CE/LB/UB are permanently enabled.
module sram_pin_drv
    import sram_arb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  state_t             i_next_state,
    input  logic [SRAM_DW-1:0] i_wr_data,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic [SRAM_DW-1:0] o_dq_in,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    logic r_we_n;
    logic r_oe_n;
    logic r_dq_oe;
    logic w_we_n;
    logic w_oe_n;
    logic w_dq_oe;

    // Strobe decode of the state the FSM is about to enter.
    always_comb begin
        w_we_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_dq_oe = 1'b0;
        case (i_next_state)
            WR_SETUP: begin
                w_dq_oe = 1'b1;
            end
            WR_STROBE: begin
                w_dq_oe = 1'b1;
                w_we_n  = 1'b0;
            end
            RD_ADDR, RD_CAPT: begin
                w_oe_n = 1'b0;
            end
            default: begin
                w_we_n  = 1'b1;
                w_oe_n  = 1'b1;
                w_dq_oe = 1'b0;
            end
        endcase
    end

    // Registering the decode keeps the strobes glitch-free and aligned with the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_we_n  <= w_we_n;
            r_oe_n  <= w_oe_n;
            r_dq_oe <= w_dq_oe;
        end
    end

    assign io_SRAM_DQ  = r_dq_oe ? i_wr_data : {SRAM_DW{1'bz}};
    assign o_dq_in     = io_SRAM_DQ;
    assign o_SRAM_WE_N = r_we_n;
    assign o_SRAM_OE_N = r_oe_n;
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (write/read) arbiter for an asynchronous 16-bit SRAM, 3 cycles per access.
// Define SRAM_ARBITER_RR_EN for round-robin tie-break; default is fixed write priority.
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_req,
    input  logic [SRAM_AW-1:0] i_wr_addr,
    input  logic [SRAM_DW-1:0] i_wr_data,
    output logic               o_wr_ack,
    input  logic               i_rd_req,
    input  logic [SRAM_AW-1:0] i_rd_addr,
    output logic               o_rd_ack,
    output logic [SRAM_DW-1:0] o_rd_data,
    output logic               o_rd_valid,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N,
    output logic               o_busy
);

    state_t             r_state;
    state_t             w_next_state;
    grant_t             w_gnt;
    logic               w_gnt_vld;
    logic               w_take;
    logic               w_busy_nxt;
    logic               w_wr_ack_nxt;
    logic               w_rd_ack_nxt;
    logic [SRAM_AW-1:0] r_addr;
    logic [SRAM_DW-1:0] r_wdata;
    logic [SRAM_DW-1:0] r_rd_data;
    logic [SRAM_DW-1:0] w_dq_in;
    logic               r_wr_ack;
    logic               r_rd_ack;
    logic               r_rd_valid;
    logic               r_busy;
`ifdef SRAM_ARBITER_RR_EN
    grant_t             r_last_gnt;
`endif

    // Arbitration between the two pending requests.
    always_comb begin
        w_gnt_vld = i_wr_req | i_rd_req;
`ifdef SRAM_ARBITER_RR_EN
        w_gnt = pick_grant(i_wr_req, i_rd_req, r_last_gnt);
`else
        if (i_wr_req) begin
            w_gnt = GNT_WR;
        end else begin
            w_gnt = GNT_RD;
        end
`endif
    end

    assign w_take = (r_state == IDLE) && w_gnt_vld;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_next_state = (w_gnt == GNT_WR) ? WR_SETUP : RD_ADDR;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WR_SETUP:  w_next_state = WR_STROBE;
            WR_STROBE: w_next_state = IDLE;
            RD_ADDR:   w_next_state = RD_CAPT;
            RD_CAPT:   w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Output decode is taken from the next state so the outputs can be registered.
    always_comb begin
        w_busy_nxt   = (w_next_state != IDLE);
        w_wr_ack_nxt = (w_next_state == WR_STROBE);
        w_rd_ack_nxt = (w_next_state == RD_CAPT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= {SRAM_DW{1'b0}};
            r_addr     <= {SRAM_AW{1'b0}};
            r_wdata    <= {SRAM_DW{1'b0}};
        end else begin
            r_busy     <= w_busy_nxt;
            r_wr_ack   <= w_wr_ack_nxt;
            r_rd_ack   <= w_rd_ack_nxt;
            r_rd_valid <= (r_state == RD_CAPT);
            if (r_state == RD_CAPT) begin
                r_rd_data <= w_dq_in;
            end else begin
                r_rd_data <= r_rd_data;
            end
            if (w_take && (w_gnt == GNT_WR)) begin
                r_addr  <= i_wr_addr;
                r_wdata <= i_wr_data;
            end else if (w_take) begin
                r_addr  <= i_rd_addr;
                r_wdata <= r_wdata;
            end else begin
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
            end
        end
    end

`ifdef SRAM_ARBITER_RR_EN
    // Reset value makes the first tie go to the writer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_gnt <= GNT_RD;
        end else if (w_take) begin
            r_last_gnt <= w_gnt;
        end else begin
            r_last_gnt <= r_last_gnt;
        end
    end
`endif

    sram_pin_drv u_pin_drv (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_next_state (w_next_state),
        .i_wr_data    (r_wdata),
        .io_SRAM_DQ   (io_SRAM_DQ),
        .o_dq_in      (w_dq_in),
        .o_SRAM_WE_N  (o_SRAM_WE_N),
        .o_SRAM_CE_N  (o_SRAM_CE_N),
        .o_SRAM_OE_N  (o_SRAM_OE_N),
        .o_SRAM_LB_N  (o_SRAM_LB_N),
        .o_SRAM_UB_N  (o_SRAM_UB_N)
    );

    assign o_SRAM_ADDR = r_addr;
    assign o_wr_ack    = r_wr_ack;
    assign o_rd_ack    = r_rd_ack;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_busy      = r_busy;

endmodule
